jump_charge: RTL

JUMP_CHARGE -- requirements
Module: jump_charge

---
 rtl/jump_charge.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/jump_charge.sv
// Jump-button charge meter: synchronizes and debounces a raw button, accumulates a
// distance while held, and reports it on release after a debounce and lockout window.
module jump_charge #(
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          TICK_DIV        = 8,
    parameter logic [7:0]  MAX_DIST        = 8'd60,
    parameter int          LOCKOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       btn,
    output logic [7:0] jump_dist,
    output logic       charging,
    output logic       saturated,
    output logic       jump_done,
    output logic [7:0] last_dist
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_DEB = 3'd1,
        CHARGING  = 3'd2,
        REL_DEB   = 3'd3,
        LOCKOUT   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                btn_s;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [7:0]          charge_q, charge_d;
    logic [7:0]          jump_dist_q, jump_dist_d;
    logic                charging_q, charging_d;
    logic                saturated_q, saturated_d;
    logic                jump_done_q, jump_done_d;
    logic [7:0]          last_dist_q, last_dist_d;
    logic                active_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Button synchronizer chain
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        tick_d      = tick_q;
        lock_d      = lock_q;
        charge_d    = charge_q;
        last_dist_d = last_dist_q;
        jump_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_DEB;
                    deb_d   = DEB_W'(1);
                end else begin
                    deb_d   = '0;
                end
            end
            PRESS_DEB: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q >= DEB_LAST) begin
                    state_d  = CHARGING;
                    deb_d    = '0;
                    charge_d = 8'd1;
                    tick_d   = '0;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            CHARGING: begin
                // The tick runs on every edge spent here, including the one that leaves.
                if (tick_q >= TICK_LAST) begin
                    tick_d = '0;
                    if (charge_q != MAX_DIST) begin
                        charge_d = charge_q + 8'd1;
                    end else begin
                        charge_d = charge_q;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
                if (!btn_s) begin
                    state_d = REL_DEB;
                    deb_d   = DEB_W'(1);
                end else begin
                    deb_d   = '0;
                end
            end
            REL_DEB: begin
                if (btn_s) begin
                    state_d = CHARGING;
                    deb_d   = '0;
                end else if (deb_q >= DEB_LAST) begin
                    state_d     = LOCKOUT;
                    deb_d       = '0;
                    lock_d      = '0;
                    tick_d      = '0;
                    jump_done_d = 1'b1;
                    last_dist_d = charge_q;
                    charge_d    = 8'd0;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            LOCKOUT: begin
                if (lock_q >= LOCK_LAST) begin
                    state_d = IDLE;
                    lock_d  = '0;
                end else begin
                    lock_d  = lock_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                deb_d    = '0;
                tick_d   = '0;
                lock_d   = '0;
                charge_d = 8'd0;
            end
        endcase
    end

    // Outputs are derived from the upcoming state so they register on the same edge
    always_comb begin
        active_s    = (state_d == CHARGING) || (state_d == REL_DEB);
        jump_dist_d = active_s ? charge_d : 8'd0;
        charging_d  = active_s;
        saturated_d = active_s && (charge_d == MAX_DIST);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            state_q     <= IDLE;
            deb_q       <= '0;
            tick_q      <= '0;
            lock_q      <= '0;
            charge_q    <= 8'd0;
            jump_dist_q <= 8'd0;
            charging_q  <= 1'b0;
            saturated_q <= 1'b0;
            jump_done_q <= 1'b0;
            last_dist_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            tick_q      <= tick_d;
            lock_q      <= lock_d;
            charge_q    <= charge_d;
            jump_dist_q <= jump_dist_d;
            charging_q  <= charging_d;
            saturated_q <= saturated_d;
            jump_done_q <= jump_done_d;
            last_dist_q <= last_dist_d;
        end
    end

    assign jump_dist = jump_dist_q;
    assign charging  = charging_q;
    assign saturated = saturated_q;
    assign jump_done = jump_done_q;
    assign last_dist = last_dist_q;

endmodule
